rs232_tx_scheduler: RTL and testbench
=====================================

// Module: rs232_tx_scheduler
// PURPOSE
//  Shares one RS232 transmit line among NUM_REQ byte requesters using round-robin arbitration.
//  Sequences each frame: start bit, data bits LSB first, optional parity, stop bits.
//  Owns the BaudRateGenerator instance's configuration: drives its baudRate divisor and its active-low reset.
//  Zeroes the generator's counter at every frame start, so bit timing is phase-aligned to the grant.
// PARAMETERS
//  NUM_REQ     4          number of requesters (2..8)
//  DATA_BITS   8          data bits per frame (5..8)
//  STOP_BITS   1          stop bits per frame (1..2)
//  BAUD_DIV    15'd5208   reset divisor (50 MHz / 9600)
// PORTS
//  clk         in   1                  system clock, all logic on posedge
//  rst         in   1                  synchronous reset, active-high
//  req         in   NUM_REQ            per-requester level request
//  req_data    in   NUM_REQ*DATA_BITS  flattened bytes; requester i in [i*DATA_BITS +: DATA_BITS]
//  gnt         out  NUM_REQ            one-hot, 1-cycle pulse; data latched that cycle
//  done        out  1                  1-cycle pulse after last stop bit
//  busy        out  1                  high from grant cycle through done cycle
//  tx          out  1                  serial line, idle high
//  cfg_wr      in   1                  divisor write strobe
//  cfg_div     in   15                 new divisor
//  cfg_err     out  1                  1-cycle pulse: write rejected (cfg_div==0)
//  baud_rate   out  15                 to generator baudRate
//  baud_rst_n  out  1                  to generator rst (active-low)
//  baud_tick   in   1                  generator baud output, 1-cycle pulse
// BEHAVIOUR
//  Reset values: gnt=0, done=0, busy=0, tx=1, cfg_err=0, baud_rate=BAUD_DIV, baud_rst_n=1, rr_ptr=0, pend=0.
//  Reset clears state to IDLE; reset mid-frame drives tx=1 on the next edge, and the partial frame is dropped.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> DONE -> IDLE.
//  IDLE, req!=0: pick the first set req at index >= rr_ptr, wrapping modulo NUM_REQ.
//   Same edge: gnt[k]=1, latch req_data[k], rr_ptr=(k+1)%NUM_REQ, baud_rst_n=0 (one cycle), busy=1, go to START.
//  START: tx=0; on baud_tick go to DATA with bit_cnt=0.
//  DATA: tx=shift[bit_cnt]; each baud_tick increments bit_cnt.
//   Tick at bit_cnt==DATA_BITS-1 goes to PARITY (if enabled), otherwise to STOP.
//  STOP: tx=1; count STOP_BITS ticks, then go to DONE.
//  DONE: done=1 and busy=1 for one cycle, tx=1, then go to IDLE.
//   Next grant is possible on the following cycle: 2 idle cycles min between frames.
//  Frame length = (1+DATA_BITS+P+STOP_BITS) ticks, with P=1 only when PARITY_EN is defined.
//  baud_tick in IDLE/DONE is ignored. req deassert after grant has no effect.
//  req held by a granted requester re-requests; with other reqs pending, it is served after them.
//  Divisor config:
//   cfg_wr & cfg_div==0: ignored, cfg_err=1 next cycle (any state).
//   cfg_wr in IDLE with no grant that cycle: baud_rate=cfg_div next edge.
//   Otherwise (busy, or grant same cycle): store in pend_div with pend=1.
//   Pending value is applied on the DONE cycle's edge, so it is in effect before the next grant.
//   A later write overwrites pend_div (last write wins).
//  baud_rst_n pulse guarantees the first tick arrives baud_rate+1 cycles after the grant edge.
// CONFIGURATION
//  PARITY_EN defined: PARITY state inserted after DATA.
//   tx = XOR of latched data bits (even parity) for one tick.
//  PARITY_EN undefined: no PARITY state, no parity logic; DATA goes straight to STOP.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> tx=1, busy=0, gnt=0, baud_rate=5208.
//  2 Single frame: cfg_div=4 in IDLE, then req=4'b0001, data=8'hA5.
//    Expect gnt=0001 one cycle, baud_rst_n low one cycle.
//    tx sequence per tick: 0,1,0,1,0,0,1,0,1,1, then done pulse.
//    With PARITY_EN, parity bit 0 appears before the stop bit.
//  3 Round robin: req=4'b1111 held -> grants 0001,0010,0100,1000,0001.
//    Each grant 1 cycle after the previous done.
//  4 Config while busy: cfg_wr div=8 mid-frame -> baud_rate unchanged until DONE, 8 afterwards.
//    cfg_div=0 -> cfg_err pulse, baud_rate unchanged.
//  5 Reset mid-DATA: rst at bit 3 -> tx=1 next edge, busy=0.
//    req still high -> fresh grant to index 0 after reset releases.
//  6 Spurious ticks: baud_tick pulsed in IDLE with req=0 -> tx stays 1, no gnt/done.

Source files
------------

// File: rtl/rs232_tx_scheduler.sv
// rs232_tx_scheduler: round-robin shared RS232 transmitter driving its baud generator; define PARITY_EN for an even parity bit
module rs232_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter logic [14:0] BAUD_DIV = 15'd5208
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           done,
  output logic                           busy,
  output logic                           tx,
  input  logic                           cfg_wr,
  input  logic [14:0]                    cfg_div,
  output logic                           cfg_err,
  output logic [14:0]                    baud_rate,
  output logic                           baud_rst_n,
  input  logic                           baud_tick
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, DONE = 3'd4;
`ifdef PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
  logic par;
`endif
  logic [2:0] state;
  logic [PW-1:0] rr_ptr, sel;
  logic [DATA_BITS-1:0] shift;
  logic [BW-1:0] bit_cnt;
  logic stop_cnt, pend, grant, cfg_ok;
  logic [14:0] pend_div;
  assign grant = state == IDLE && |req;
  assign cfg_ok = cfg_wr && cfg_div != '0;
  // descending scan so the lowest offset from rr_ptr wins
  always_comb begin
    sel = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (req[(int'(rr_ptr) + j) % NUM_REQ]) sel = PW'((int'(rr_ptr) + j) % NUM_REQ);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      shift <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      pend <= 1'b0;
      pend_div <= '0;
      gnt <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      tx <= 1'b1;
      cfg_err <= 1'b0;
      baud_rate <= BAUD_DIV;
      baud_rst_n <= 1'b1;
`ifdef PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      gnt <= '0;
      done <= 1'b0;
      baud_rst_n <= 1'b1;
      cfg_err <= cfg_wr && cfg_div == '0;
      // a write landing on the DONE edge supersedes any pending value
      if (cfg_ok && ((state == IDLE && !grant) || state == DONE)) begin
        baud_rate <= cfg_div;
        pend <= 1'b0;
      end else if (cfg_ok) begin
        pend_div <= cfg_div;
        pend <= 1'b1;
      end else if (state == DONE && pend) begin
        baud_rate <= pend_div;
        pend <= 1'b0;
      end
      case (state)
        IDLE: if (grant) begin
          gnt <= NUM_REQ'(1) << sel;
          shift <= req_data[sel*DATA_BITS +: DATA_BITS];
`ifdef PARITY_EN
          par <= ^req_data[sel*DATA_BITS +: DATA_BITS];
`endif
          rr_ptr <= sel == PW'(NUM_REQ - 1) ? '0 : sel + 1'b1;
          baud_rst_n <= 1'b0;
          busy <= 1'b1;
          tx <= 1'b0;
          stop_cnt <= 1'b0;
          state <= START;
        end
        START: if (baud_tick) begin
          state <= DATA;
          bit_cnt <= '0;
          tx <= shift[0];
          shift <= shift >> 1;
        end
        DATA: if (baud_tick) begin
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef PARITY_EN
            state <= PARITY;
            tx <= par;
`else
            state <= STOP;
            tx <= 1'b1;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            tx <= shift[0];
            shift <= shift >> 1;
          end
        end
`ifdef PARITY_EN
        PARITY: if (baud_tick) begin
          state <= STOP;
          tx <= 1'b1;
        end
`endif
        STOP: if (baud_tick) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state <= DONE;
            done <= 1'b1;
          end else stop_cnt <= 1'b1;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rs232_tx_scheduler.sv
// tb_rs232_tx_scheduler: directed table, corner sequences and random traffic against a frame-level reference model
module tb_rs232_tx_scheduler;
  localparam int NR = 4;
  localparam int DB = 8;
  localparam int SB = 1;
`ifdef PARITY_EN
  localparam int FL = 1 + DB + 1 + SB;
`else
  localparam int FL = 1 + DB + SB;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*DB-1:0] req_data = '0;
  logic [NR-1:0] gnt;
  logic done, busy, tx, cfg_wr = 1'b0, cfg_err, baud_rst_n, baud_tick, spur = 1'b0;
  logic [14:0] cfg_div = '0, baud_rate;
  int total = 0, bad = 0;
  rs232_tx_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
    .busy(busy), .tx(tx), .cfg_wr(cfg_wr), .cfg_div(cfg_div), .cfg_err(cfg_err),
    .baud_rate(baud_rate), .baud_rst_n(baud_rst_n), .baud_tick(baud_tick)
  );
  always #5 clk = ~clk;
  logic [15:0] gcnt = '0;
  always @(posedge clk)
    if (rst || !baud_rst_n) gcnt <= '0;
    else if (gcnt >= {1'b0, baud_rate} - 16'd1) gcnt <= '0;
    else gcnt <= gcnt + 16'd1;
  assign baud_tick = (baud_rst_n && gcnt == {1'b0, baud_rate} - 16'd1) || spur;
  logic rst_p, wr_p, tick_p;
  logic [NR-1:0] req_p;
  logic [NR*DB-1:0] dat_p;
  logic [14:0] div_p;
  bit m_on = 0, m_pend = 0;
  int m_ph = 0, m_b = 0, m_ptr = 0;
  logic [14:0] m_baud, m_pdiv;
  logic fr [FL];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic model();
    logic [NR-1:0] eg;
    logic ed, er, ee, g, wi, wd;
    logic [DB-1:0] d;
    int k;
    eg = '0; ed = 0; er = 1; ee = 0; k = 0;
    if (!m_on && !rst_p) return;
    if (rst_p) begin
      m_on = 1; m_ph = 0; m_ptr = 0; m_baud = 15'd5208; m_pend = 0; m_pdiv = '0;
    end else begin
      ee = wr_p && div_p == 0;
      g = m_ph == 0 && req_p != 0;
      wi = m_ph == 0;
      wd = m_ph == 2;
      if (wr_p && div_p != 0) begin
        if ((wi && !g) || wd) begin m_baud = div_p; m_pend = 0; end
        else begin m_pdiv = div_p; m_pend = 1; end
      end else if (wd && m_pend) begin
        m_baud = m_pdiv; m_pend = 0;
      end
      if (m_ph == 0) begin
        if (g) begin
          for (int o = 0; o < NR; o++)
            if (req_p[(m_ptr + o) % NR]) begin k = (m_ptr + o) % NR; break; end
          eg = NR'(1) << k;
          m_ptr = (k + 1) % NR;
          d = dat_p[k*DB +: DB];
          for (int i = 0; i < FL; i++) fr[i] = 1'b1;
          fr[0] = 1'b0;
          for (int i = 0; i < DB; i++) fr[1+i] = d[i];
`ifdef PARITY_EN
          fr[1+DB] = ^d;
`endif
          m_b = 0; m_ph = 1; er = 0;
        end
      end else if (m_ph == 1) begin
        if (tick_p) begin
          m_b++;
          if (m_b == FL) begin m_ph = 2; ed = 1; end
        end
      end else m_ph = 0;
    end
    chk("tx", tx, m_ph == 1 ? fr[m_b] : 1'b1);
    chk("busy", busy, m_ph != 0);
    chk("gnt", gnt, eg);
    chk("done", done, ed);
    chk("cfg_err", cfg_err, ee);
    chk("baud_rate", baud_rate, m_baud);
    chk("baud_rst_n", baud_rst_n, er);
  endtask
  task automatic step();
    @(negedge clk);
    rst_p = rst; req_p = req; dat_p = req_data; wr_p = cfg_wr; div_p = cfg_div; tick_p = baud_tick;
    @(posedge clk);
    #1;
    model();
  endtask
  task automatic wait_gnt();
    for (int i = 0; i < 300; i++) begin
      step();
      if (gnt != 0) break;
    end
    chk("gnt_seen", gnt != 0, 1);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      step();
      if (done) break;
    end
    chk("done_seen", done, 1);
  endtask
  task automatic set_div(input logic [14:0] v);
    cfg_wr = 1; cfg_div = v;
    step();
    cfg_wr = 0;
  endtask
  typedef struct {
    logic [NR-1:0] rq;
    logic [NR*DB-1:0] dat;
    logic [NR-1:0] eg;
    logic [DB-1:0] eb;
  } vec_t;
  vec_t tv [9];
  logic [3:0] rr_exp [5];
  initial begin
    logic [DB-1:0] cap;
    int n;
    tv[0] = '{4'b0001, 32'h000000A5, 4'b0001, 8'hA5};
    tv[1] = '{4'b1111, 32'h44332211, 4'b0010, 8'h22};
    tv[2] = '{4'b1111, 32'h44332211, 4'b0100, 8'h33};
    tv[3] = '{4'b1111, 32'h44332211, 4'b1000, 8'h44};
    tv[4] = '{4'b1111, 32'h44332211, 4'b0001, 8'h11};
    tv[5] = '{4'b0001, 32'h0000003C, 4'b0001, 8'h3C};
    tv[6] = '{4'b1001, 32'hF000000F, 4'b1000, 8'hF0};
    tv[7] = '{4'b0110, 32'h00C35A00, 4'b0010, 8'h5A};
    tv[8] = '{4'b0110, 32'h00C35A00, 4'b0100, 8'hC3};
    rr_exp = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    step();
    step();
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_baud", baud_rate, 15'd5208);
    rst = 0;
    set_div(15'd4);
    chk("cfg_idle", baud_rate, 4);
    for (int v = 0; v < 9; v++) begin
      req = tv[v].rq; req_data = tv[v].dat;
      wait_gnt();
      chk("tv_gnt", gnt, tv[v].eg);
      chk("tv_baud_rst_n", baud_rst_n, 0);
      req = '0;
      cap = '0; n = 0;
      for (int i = 0; i < 3000; i++) begin
        step();
        if (tick_p) begin
          n++;
          if (n >= 1 && n <= DB) cap[n-1] = tx;
        end
        if (done) break;
      end
      chk("tv_done", done, 1);
      chk("tv_byte", cap, tv[v].eb);
    end
    req = 4'b1111; req_data = 32'h9A7B3C5D;
    wait_gnt();
    for (int g = 0; g < 5; g++) begin
      chk("rr_gnt", gnt, rr_exp[g]);
      if (g == 4) break;
      wait_done();
      step();
      chk("rr_gap", gnt, 0);
      step();
    end
    req = '0;
    wait_done();
    req = 4'b0001; req_data = 32'h000000A5;
    wait_gnt();
    req = '0;
    repeat (10) step();
    set_div(15'd8);
    chk("cfg_busy_hold", baud_rate, 4);
    wait_done();
    chk("cfg_done_cycle", baud_rate, 4);
    step();
    chk("cfg_applied", baud_rate, 8);
    set_div(15'd0);
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_keep", baud_rate, 8);
    step();
    chk("cfg_err_clear", cfg_err, 0);
    set_div(15'd4);
    req = 4'b0001; req_data = 32'h000000A5;
    wait_gnt();
    n = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (tick_p) n++;
      if (n == 4) break;
    end
    chk("mid_bit3", tx, 0);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    wait_gnt();
    chk("mid_regrant", gnt, 4'b0001);
    rst = 1; req = '0;
    step();
    rst = 0;
    set_div(15'd4);
    for (int i = 0; i < 8; i++) begin
      spur = i[0];
      step();
      chk("spur_tx", tx, 1);
      chk("spur_gnt", gnt, 0);
      chk("spur_done", done, 0);
    end
    spur = 0;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1; req = '0; cfg_wr = 0; spur = 0;
        step();
        rst = 0;
        set_div(15'd3);
      end
      if ($urandom_range(0, 3) == 0) req = NR'($urandom);
      if ($urandom_range(0, 7) == 0) req_data = $urandom;
      cfg_wr = $urandom_range(0, 49) == 0;
      cfg_div = $urandom_range(0, 7) == 0 ? 15'd0 : 15'($urandom_range(2, 6));
      spur = $urandom_range(0, 59) == 0;
      step();
    end
    cfg_wr = 0; spur = 0; req = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
